instruction_fetch: RTL and testbench
====================================

Name: instruction_fetch

Overview:
- IF stage of the 5-stage MIPS pipeline, directly upstream of the decode stage.
- Holds the PC and a word-addressed instruction memory. The debug unit loads the program through a write port.
- Produces the IF/ID pipeline register: instruction plus PC+4. Consumes the jump/branch redirect resolved in decode.
- Runs a LOAD/RUN/HALTED sequence so the program is loaded, executed, and frozen on the HALT word 0xFFFFFFFF.

Parameters:
- NB_DATA, 32, data/instruction/PC width.
- NB_MEM_ADDR, 8, instruction memory word-index width; depth = 2**NB_MEM_ADDR words.
- HALT_WORD, 32'hFFFFFFFF, end-of-program instruction encoding.

Ports:
- clk  in  1  system clock, rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_start  in  1  one-cycle pulse from debug unit; LOAD->RUN.
- i_halt  in  1  global pipeline freeze (debug step control); nothing in this block updates while high.
- i_stall  in  1  load-use hazard from hazard unit; hold PC and IF/ID.
- i_jump  in  1  taken jump/branch from decode (combinational, same cycle).
- i_addr2jump  in  NB_DATA  redirect target byte address.
- i_wr_en  in  1  program-load word write strobe.
- i_wr_addr  in  NB_MEM_ADDR  program-load word index.
- i_wr_data  in  NB_DATA  program-load word.
- o_instruction  out  NB_DATA  IF/ID instruction register.
- o_pcounter4  out  NB_DATA  IF/ID PC+4 of o_instruction.
- o_pc  out  NB_DATA  current PC (debug readback).
- o_running  out  1  state == RUN.
- o_halted  out  1  state == HALTED.

Behaviour:
- Reset (async, any state, mid-operation included):
  - state=LOAD.
  - PC, o_instruction, o_pcounter4 = 0 (o_instruction=0 is NOP).
  - o_running=o_halted=0.
  - Memory contents are NOT cleared.
- Memory:
  - Asynchronous read at word index PC[NB_MEM_ADDR+1:2]. PC bits [1:0] are ignored.
  - PC bits above the index are ignored (address wraps modulo depth).
  - Synchronous write on i_wr_en, accepted only in LOAD. Ignored in RUN/HALTED.
- States:
  - LOAD:
    - PC held 0; IF/ID outputs NOP/0.
    - i_start -> RUN next cycle, even if i_wr_en is high in the same cycle. That write is still performed.
  - RUN: per-cycle update, first matching rule wins:
    - 1. i_halt: all registers hold.
    - 2. i_stall: PC and IF/ID hold. i_jump is ignored, because decode operands are invalid during a stall.
    - 3. i_jump: PC<=i_addr2jump; o_instruction<=0 (flush); o_pcounter4<=PC+4. HALT detection is suppressed.
    - 4. mem[PC]==HALT_WORD: o_instruction<=HALT_WORD; o_pcounter4<=PC+4; PC holds; state->HALTED.
    - 5. Normal: o_instruction<=mem[PC]; o_pcounter4<=PC+4; PC<=PC+4.
  - HALTED:
    - PC and o_instruction (=HALT_WORD) held, so decode keeps asserting its stop flag.
    - Exit only via i_rst. i_start is ignored.
- Latency: instruction at PC appears on o_instruction 1 cycle after PC presents it. Redirect takes effect on the next fetch, with one flushed slot.
- PC+4 arithmetic is modulo 2**NB_DATA. An unaligned i_addr2jump is used with bits [1:0] ignored for the read; o_pc reports it unmodified.
- o_running/o_halted are registered state decodes.

Optional Feature:
- Macro: IF_FETCH_COUNT_EN.
- When defined:
  - Adds output o_fetch_count (32 bits), reset 0.
  - Increments by 1 on every RUN-state rule-5 or rule-4 update. Does not increment on halt, stall, jump flush, LOAD or HALTED.
  - Saturates at 32'hFFFFFFFF.
- When undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Load and run:
  - Stimulus: write words 0..3 = 0x20010005, 0x20020007, 0x00221820, 0xFFFFFFFF in LOAD, then pulse i_start.
  - Required: o_instruction sequence 0x20010005/PC4=4, 0x20020007/8, 0x00221820/12, 0xFFFFFFFF/16. o_halted=1; PC stays 12 thereafter.
- Jump flush:
  - Stimulus: in RUN at PC=8, assert i_jump=1, i_addr2jump=0x40 for one cycle.
  - Required: next o_instruction=0 with o_pcounter4=12; PC=0x40; following o_instruction=mem[16], o_pcounter4=0x44.
- Stall vs jump:
  - Stimulus: i_stall=1 and i_jump=1 in the same cycle at PC=4.
  - Required: PC stays 4; IF/ID unchanged; jump ignored.
- Freeze:
  - Stimulus: assert i_halt for 3 cycles mid-RUN.
  - Required: PC, o_instruction, o_pcounter4 unchanged; fetching resumes at the same PC on release.
- Write lockout and reset:
  - Stimulus: i_wr_en to index 0 while in RUN, then i_rst mid-RUN.
  - Required: mem[0] unchanged; after reset state=LOAD, PC=0, outputs 0. Memory retained, so re-pulsing i_start replays the same program.
- Counter (IF_FETCH_COUNT_EN):
  - Stimulus: run the first scenario with one injected stall.
  - Required: o_fetch_count=4 at HALTED.

Source files
------------

// File: rtl/instruction_fetch.sv
// IF stage of the 5-stage MIPS pipeline: PC, program memory and the IF/ID register.
// Optional fetch counter is enabled by defining IF_FETCH_COUNT_EN.
module instruction_fetch #(
    parameter int                 NB_DATA     = 32,
    parameter int                 NB_MEM_ADDR = 8,
    parameter logic [NB_DATA-1:0] HALT_WORD   = 32'hFFFFFFFF
) (
    input  logic                   clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_halt,
    input  logic                   i_stall,
    input  logic                   i_jump,
    input  logic [NB_DATA-1:0]     i_addr2jump,
    input  logic                   i_wr_en,
    input  logic [NB_MEM_ADDR-1:0] i_wr_addr,
    input  logic [NB_DATA-1:0]     i_wr_data,
    output logic [NB_DATA-1:0]     o_instruction,
    output logic [NB_DATA-1:0]     o_pcounter4,
    output logic [NB_DATA-1:0]     o_pc,
    output logic                   o_running,
    output logic                   o_halted
`ifdef IF_FETCH_COUNT_EN
    ,
    output logic [31:0]            o_fetch_count
`endif
);

    localparam int                 DEPTH   = 2 ** NB_MEM_ADDR;
    localparam logic [NB_DATA-1:0] PC_STEP = NB_DATA'(3'd4);

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_e;

    state_e               state_q;
    logic [NB_DATA-1:0]   pc_q;
    logic [NB_DATA-1:0]   instr_q;
    logic [NB_DATA-1:0]   pc4_q;
    logic                 running_q;
    logic                 halted_q;
    logic [NB_DATA-1:0]   mem_q [DEPTH];

    logic [NB_MEM_ADDR-1:0] fetch_idx_s;
    logic [NB_DATA-1:0]     fetch_word_s;
    logic [NB_DATA-1:0]     pc_plus4_s;
    logic                   wr_ok_s;

    // Byte PC to word index; low two bits and bits above the index are dropped.
    assign fetch_idx_s  = pc_q[NB_MEM_ADDR+1:2];
    assign fetch_word_s = mem_q[fetch_idx_s];
    assign pc_plus4_s   = pc_q + PC_STEP;
    assign wr_ok_s      = i_wr_en && !i_halt && (state_q == ST_LOAD);

    // Program-load write port; contents survive reset so a program can be replayed.
    always_ff @(posedge clk) begin
        if (wr_ok_s) begin
            mem_q[i_wr_addr] <= i_wr_data;
        end
    end

    // Sequencer, PC and IF/ID register.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_LOAD;
            pc_q      <= '0;
            instr_q   <= '0;
            pc4_q     <= '0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
        end else if (!i_halt) begin
            case (state_q)
                ST_LOAD: begin
                    pc_q    <= '0;
                    instr_q <= '0;
                    pc4_q   <= '0;
                    if (i_start) begin
                        state_q   <= ST_RUN;
                        running_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (i_stall) begin
                        // Decode operands are not valid during a load-use stall, so a jump is dropped.
                        pc_q    <= pc_q;
                        instr_q <= instr_q;
                        pc4_q   <= pc4_q;
                    end else if (i_jump) begin
                        pc_q    <= i_addr2jump;
                        instr_q <= '0;
                        pc4_q   <= pc_plus4_s;
                    end else if (fetch_word_s == HALT_WORD) begin
                        instr_q   <= HALT_WORD;
                        pc4_q     <= pc_plus4_s;
                        state_q   <= ST_HALTED;
                        running_q <= 1'b0;
                        halted_q  <= 1'b1;
                    end else begin
                        instr_q <= fetch_word_s;
                        pc4_q   <= pc_plus4_s;
                        pc_q    <= pc_plus4_s;
                    end
                end
                ST_HALTED: begin
                    pc_q    <= pc_q;
                    instr_q <= instr_q;
                end
                default: begin
                    state_q   <= ST_LOAD;
                    running_q <= 1'b0;
                    halted_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_instruction = instr_q;
    assign o_pcounter4   = pc4_q;
    assign o_pc          = pc_q;
    assign o_running     = running_q;
    assign o_halted      = halted_q;

`ifdef IF_FETCH_COUNT_EN
    logic [31:0] fetch_count_q;
    logic        fetch_s;

    assign fetch_s = (state_q == ST_RUN) && !i_halt && !i_stall && !i_jump;

    // Counts real memory fetches, including the one that lands on the halt word.
    always_ff @(posedge clk or posedge i_rst) begin
        if (i_rst) begin
            fetch_count_q <= 32'd0;
        end else if (fetch_s && (fetch_count_q != 32'hFFFFFFFF)) begin
            fetch_count_q <= fetch_count_q + 32'd1;
        end
    end

    assign o_fetch_count = fetch_count_q;
`endif

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a randomized
// run compared against a cycle model built from the fetch rules.
module tb_instruction_fetch;

    localparam logic [31:0] HALT = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        i_rst, i_start, i_halt, i_stall, i_jump, i_wr_en;
    logic [31:0] i_addr2jump, i_wr_data;
    logic [7:0]  i_wr_addr;
    logic [31:0] o_instruction, o_pcounter4, o_pc;
    logic        o_running, o_halted;
`ifdef IF_FETCH_COUNT_EN
    logic [31:0] o_fetch_count;
`endif

    int total = 0;
    int bad   = 0;

    // Reference model state: mode 0=LOAD 1=RUN 2=HALTED
    int          m_mode;
    logic [31:0] m_pc, m_ins, m_pc4, m_cnt;
    logic [31:0] m_mem [256];

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk           (clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_halt        (i_halt),
        .i_stall       (i_stall),
        .i_jump        (i_jump),
        .i_addr2jump   (i_addr2jump),
        .i_wr_en       (i_wr_en),
        .i_wr_addr     (i_wr_addr),
        .i_wr_data     (i_wr_data),
        .o_instruction (o_instruction),
        .o_pcounter4   (o_pcounter4),
        .o_pc          (o_pc),
        .o_running     (o_running),
        .o_halted      (o_halted)
`ifdef IF_FETCH_COUNT_EN
        ,
        .o_fetch_count (o_fetch_count)
`endif
    );

    task automatic idle();
        i_start = 1'b0; i_halt = 1'b0; i_stall = 1'b0; i_jump = 1'b0;
        i_addr2jump = 32'd0; i_wr_en = 1'b0; i_wr_addr = 8'd0; i_wr_data = 32'd0;
    endtask

    task automatic model_reset();
        m_mode = 0; m_pc = 32'd0; m_ins = 32'd0; m_pc4 = 32'd0; m_cnt = 32'd0;
    endtask

    // Advance the model by one clock using the inputs currently driven, then clock the DUT.
    task automatic cyc();
        logic [31:0] w;
        if (!i_halt) begin
            case (m_mode)
                0: begin
                    if (i_wr_en) m_mem[i_wr_addr] = i_wr_data;
                    if (i_start) m_mode = 1;
                end
                1: begin
                    if (i_stall) begin
                        m_mode = 1;
                    end else if (i_jump) begin
                        m_pc4 = m_pc + 32'd4;
                        m_ins = 32'd0;
                        m_pc  = i_addr2jump;
                    end else begin
                        w = m_mem[(m_pc / 32'd4) % 32'd256];
                        m_ins = w;
                        m_pc4 = m_pc + 32'd4;
                        if (m_cnt != 32'hFFFFFFFF) m_cnt = m_cnt + 32'd1;
                        if (w == HALT) m_mode = 2;
                        else m_pc = m_pc + 32'd4;
                    end
                end
                default: m_mode = m_mode;
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        i_rst = 1'b1;
        model_reset();
        @(posedge clk);
        #1;
        i_rst = 1'b0;
    endtask

    task automatic load_word(input logic [7:0] a, input logic [31:0] d);
        i_wr_en = 1'b1; i_wr_addr = a; i_wr_data = d;
        cyc();
        i_wr_en = 1'b0;
    endtask

    task automatic pulse_start();
        i_start = 1'b1;
        cyc();
        i_start = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        i_rst = 1'b1;
        model_reset();
        #3;
        total++; if (o_pc !== 32'd0) begin bad++; $display("FAIL reset_pc got=%h exp=0", o_pc); end
        total++; if (o_instruction !== 32'd0) begin bad++; $display("FAIL reset_instr got=%h exp=0", o_instruction); end
        total++; if (o_pcounter4 !== 32'd0) begin bad++; $display("FAIL reset_pc4 got=%h exp=0", o_pcounter4); end
        total++; if (o_running !== 1'b0 || o_halted !== 1'b0) begin bad++; $display("FAIL reset_flags got=%b%b exp=00", o_running, o_halted); end
`ifdef IF_FETCH_COUNT_EN
        total++; if (o_fetch_count !== 32'd0) begin bad++; $display("FAIL reset_count got=%0d exp=0", o_fetch_count); end
`endif
        @(posedge clk);
        #1;
        i_rst = 1'b0;
    endtask

    task automatic test_load_run();
        logic [31:0] prog [4]    = '{32'h20010005, 32'h20020007, 32'h00221820, 32'hFFFFFFFF};
        logic [31:0] exp_pc4 [4] = '{32'd4, 32'd8, 32'd12, 32'd16};
        logic [31:0] w;
        for (int i = 0; i < 256; i++) begin
            w = $urandom();
            if (w == HALT) w = 32'd0;
            load_word(8'(i), w);
        end
        for (int i = 0; i < 4; i++) load_word(8'(i), prog[i]);
        total++; if (o_running !== 1'b0 || o_pc !== 32'd0) begin bad++; $display("FAIL load_hold run=%b pc=%h exp run=0 pc=0", o_running, o_pc); end
        pulse_start();
        total++; if (o_running !== 1'b1 || o_instruction !== 32'd0) begin bad++; $display("FAIL start run=%b ins=%h exp run=1 ins=0", o_running, o_instruction); end
        for (int k = 0; k < 4; k++) begin
            cyc();
            total++; if (o_instruction !== prog[k] || o_pcounter4 !== exp_pc4[k]) begin
                bad++; $display("FAIL run_seq%0d ins=%h pc4=%h exp ins=%h pc4=%h", k, o_instruction, o_pcounter4, prog[k], exp_pc4[k]);
            end
        end
        total++; if (o_halted !== 1'b1 || o_running !== 1'b0 || o_pc !== 32'd12) begin bad++; $display("FAIL halted halt=%b run=%b pc=%h exp 1 0 c", o_halted, o_running, o_pc); end
        pulse_start();
        cyc();
        total++; if (o_pc !== 32'd12 || o_instruction !== HALT || o_halted !== 1'b1) begin bad++; $display("FAIL halted_hold pc=%h ins=%h halt=%b", o_pc, o_instruction, o_halted); end
`ifdef IF_FETCH_COUNT_EN
        total++; if (o_fetch_count !== 32'd4) begin bad++; $display("FAIL run_count got=%0d exp=4", o_fetch_count); end
`endif
    endtask

    task automatic test_jump_flush();
        do_reset();
        pulse_start();
        cyc();
        cyc();
        total++; if (o_pc !== 32'd8) begin bad++; $display("FAIL jump_setup pc=%h exp=8", o_pc); end
        i_jump = 1'b1; i_addr2jump = 32'h40;
        cyc();
        i_jump = 1'b0; i_addr2jump = 32'd0;
        total++; if (o_instruction !== 32'd0 || o_pcounter4 !== 32'd12 || o_pc !== 32'h40) begin
            bad++; $display("FAIL jump_flush ins=%h pc4=%h pc=%h exp 0 c 40", o_instruction, o_pcounter4, o_pc);
        end
        cyc();
        total++; if (o_instruction !== m_mem[16] || o_pcounter4 !== 32'h44) begin
            bad++; $display("FAIL jump_target ins=%h pc4=%h exp ins=%h pc4=44", o_instruction, o_pcounter4, m_mem[16]);
        end
    endtask

    task automatic test_stall_vs_jump();
        do_reset();
        pulse_start();
        cyc();
        i_stall = 1'b1; i_jump = 1'b1; i_addr2jump = 32'h80;
        cyc();
        i_stall = 1'b0; i_jump = 1'b0; i_addr2jump = 32'd0;
        total++; if (o_pc !== 32'd4 || o_instruction !== 32'h20010005 || o_pcounter4 !== 32'd4) begin
            bad++; $display("FAIL stall_jump pc=%h ins=%h pc4=%h exp 4 20010005 4", o_pc, o_instruction, o_pcounter4);
        end
        cyc();
        total++; if (o_pc !== 32'd8 || o_instruction !== 32'h20020007) begin bad++; $display("FAIL stall_resume pc=%h ins=%h exp 8 20020007", o_pc, o_instruction); end
    endtask

    task automatic test_freeze();
        i_halt = 1'b1; i_jump = 1'b1; i_addr2jump = 32'hC0;
        for (int k = 0; k < 3; k++) begin
            cyc();
            total++; if (o_pc !== 32'd8 || o_instruction !== 32'h20020007 || o_pcounter4 !== 32'd8) begin
                bad++; $display("FAIL freeze%0d pc=%h ins=%h pc4=%h", k, o_pc, o_instruction, o_pcounter4);
            end
        end
        i_halt = 1'b0; i_jump = 1'b0; i_addr2jump = 32'd0;
        cyc();
        total++; if (o_instruction !== 32'h00221820 || o_pcounter4 !== 32'd12) begin bad++; $display("FAIL freeze_resume ins=%h pc4=%h exp 00221820 c", o_instruction, o_pcounter4); end
    endtask

    task automatic test_write_lockout_reset();
        do_reset();
        pulse_start();
        cyc();
        load_word(8'd0, 32'hDEADBEEF);
        i_rst = 1'b1;
        model_reset();
        #2;
        total++; if (o_pc !== 32'd0 || o_instruction !== 32'd0 || o_pcounter4 !== 32'd0 || o_running !== 1'b0) begin
            bad++; $display("FAIL async_reset pc=%h ins=%h pc4=%h run=%b", o_pc, o_instruction, o_pcounter4, o_running);
        end
        #2;
        i_rst = 1'b0;
        pulse_start();
        cyc();
        total++; if (o_instruction !== 32'h20010005) begin bad++; $display("FAIL lockout_replay ins=%h exp=20010005", o_instruction); end
    endtask

    task automatic test_counter();
        do_reset();
        pulse_start();
        cyc();
        cyc();
        i_stall = 1'b1;
        cyc();
        i_stall = 1'b0;
        cyc();
        cyc();
        cyc();
        total++; if (o_halted !== 1'b1 || o_pc !== 32'd12) begin bad++; $display("FAIL count_halt halt=%b pc=%h exp 1 c", o_halted, o_pc); end
`ifdef IF_FETCH_COUNT_EN
        total++; if (o_fetch_count !== 32'd4) begin bad++; $display("FAIL count_stall got=%0d exp=4", o_fetch_count); end
`endif
    endtask

    task automatic test_random();
        logic [31:0] w;
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int i = 0; i < 30; i++) begin
                w = ($urandom_range(0, 9) == 0) ? HALT : $urandom();
                load_word(8'($urandom_range(0, 63)), w);
            end
            pulse_start();
            for (int c = 0; c < 80; c++) begin
                i_halt      = ($urandom_range(0, 7) == 0);
                i_stall     = ($urandom_range(0, 5) == 0);
                i_jump      = ($urandom_range(0, 5) == 0);
                i_addr2jump = 32'($urandom_range(0, 255));
                i_start     = ($urandom_range(0, 9) == 0);
                i_wr_en     = ($urandom_range(0, 9) == 0);
                i_wr_addr   = 8'($urandom_range(0, 63));
                i_wr_data   = $urandom();
                cyc();
                total++; if (o_pc !== m_pc || o_instruction !== m_ins || o_pcounter4 !== m_pc4) begin
                    bad++; $display("FAIL rand_regs r%0d c%0d pc=%h ins=%h pc4=%h exp pc=%h ins=%h pc4=%h", r, c, o_pc, o_instruction, o_pcounter4, m_pc, m_ins, m_pc4);
                end
                total++; if (o_running !== (m_mode == 1) || o_halted !== (m_mode == 2)) begin
                    bad++; $display("FAIL rand_state r%0d c%0d run=%b halt=%b exp mode=%0d", r, c, o_running, o_halted, m_mode);
                end
`ifdef IF_FETCH_COUNT_EN
                total++; if (o_fetch_count !== m_cnt) begin bad++; $display("FAIL rand_count r%0d c%0d got=%0d exp=%0d", r, c, o_fetch_count, m_cnt); end
`endif
            end
            idle();
        end
    endtask

    initial begin
        test_reset();
        test_load_run();
        test_jump_flush();
        test_stall_vs_jump();
        test_freeze();
        test_write_lockout_reset();
        test_counter();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
